// File: rtl/adder.sv
// Registered signed adder: C is the (WIDTH+1)-bit sum of A and B,
// loaded every rising clk edge and cleared asynchronously by reset.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic signed [WIDTH:0]   C
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] c_d;
    logic signed [WIDTH:0] c_q;

    // One extra bit after sign extension makes overflow impossible.
    always_comb begin
        a_ext = {A[WIDTH-1], A};
        b_ext = {B[WIDTH-1], B};
        c_d   = a_ext + b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign C = c_q;

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for the registered signed adder.
// Inputs change at falling edges or just after rising edges.
module tb_adder;

    logic              clk;
    logic              reset;
    logic signed [3:0] A;
    logic signed [3:0] B;
    logic signed [4:0] C;

    int checks;
    int failures;

    adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .C     (C)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b1;
        A = -4'sd8;
        B = -4'sd8;
        #1;
        checks++;
        if (C !== 5'sd0) begin
            failures++;
            $display("FAIL reset_async_start C=%0d expected=0", C);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== 5'sd0) begin
            failures++;
            $display("FAIL reset_hold C=%0d expected=0", C);
        end
    endtask

    task automatic test_corners();
        int av [9] = '{-8, 0, -8, 7, 0, 7, -8, 7, 0};
        int bv [9] = '{-8, 0, 7, 0, -8, 7, 0, -8, 7};
        int ev [9] = '{-16, 0, -1, 7, -8, 14, -8, -1, 7};
        logic signed [4:0] exp5;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            A = 4'(av[i]);
            B = 4'(bv[i]);
            exp5 = 5'(ev[i]);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (C !== exp5) begin
                failures++;
                $display("FAIL corner_%0d A=%0d B=%0d C=%0d expected=%0d",
                         i, av[i], bv[i], C, ev[i]);
            end
        end
    endtask

    task automatic test_latency();
        A = 4'sd7;
        B = 4'sd7;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== 5'sd14) begin
            failures++;
            $display("FAIL latency_setup C=%0d expected=14", C);
        end
        @(posedge clk);
        #1 A = -4'sd8;
        #1;
        checks++;
        if (C !== 5'sd14) begin
            failures++;
            $display("FAIL latency_no_comb_path C=%0d expected=14", C);
        end
        @(negedge clk);
        checks++;
        if (C !== 5'sd14) begin
            failures++;
            $display("FAIL latency_hold C=%0d expected=14", C);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== -5'sd1) begin
            failures++;
            $display("FAIL latency_update C=%0d expected=-1", C);
        end
    endtask

    task automatic test_async_reset();
        A = 4'sd7;
        B = 4'sd7;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== 5'sd14) begin
            failures++;
            $display("FAIL async_setup C=%0d expected=14", C);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (C !== 5'sd0) begin
            failures++;
            $display("FAIL async_reset C=%0d expected=0", C);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== 5'sd0) begin
            failures++;
            $display("FAIL reset_over_edge C=%0d expected=0", C);
        end
    endtask

    task automatic test_reset_release();
        A = -4'sd8;
        B = 4'sd0;
        reset = 1'b0;
        #1;
        checks++;
        if (C !== 5'sd0) begin
            failures++;
            $display("FAIL release_before_edge C=%0d expected=0", C);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (C !== -5'sd8) begin
            failures++;
            $display("FAIL release_first_edge C=%0d expected=-8", C);
        end
    endtask

    task automatic test_exhaustive();
        int sa;
        int sb;
        int bad;
        logic signed [4:0] exp5;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                sa = (a > 7) ? a - 16 : a;
                sb = (b > 7) ? b - 16 : b;
                exp5 = 5'(sa + sb);
                A = 4'(a);
                B = 4'(b);
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (C !== exp5) begin
                    failures++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL exhaustive A=%0d B=%0d C=%0d expected=%0d",
                                 sa, sb, C, exp5);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        A        = '0;
        B        = '0;
        test_reset();
        test_corners();
        test_latency();
        test_async_reset();
        test_reset_release();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
- REQ-001: Parameter WIDTH, default 4, SHALL set the operand width in bits; the output width SHALL be WIDTH+1.
- REQ-002: Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-003: Port reset, input, 1 bit, SHALL be the reset; it is asynchronous and active-high.
- REQ-004: Port A, input, WIDTH bits (4 by default), SHALL be signed operand A in two's complement.
- REQ-005: Port B, input, WIDTH bits (4 by default), SHALL be signed operand B in two's complement.
- REQ-006: Port C, output, WIDTH+1 bits (5 by default), SHALL be the registered signed sum A+B in two's complement.

Function
- REQ-007: C SHALL be a register, loaded on each rising clk edge with sign-extend(A) + sign-extend(B) when reset is low.
- REQ-008: The sum SHALL be computed at WIDTH+1 bits after sign extension of both operands, so overflow SHALL never occur.
- REQ-009: The full range SHALL be exact:
  - minimum -2^WIDTH, which is -16 for -8 + -8.
  - maximum 2^WIDTH - 2, which is 14 for 7 + 7.
- REQ-010: Latency SHALL be one clock: operands stable before rising edge N SHALL produce their sum on C after edge N, valid before the following falling edge.
- REQ-011: C SHALL hold its value between rising edges; input changes SHALL have no combinational path to C.
- REQ-012: There SHALL be no handshake, enable or valid signal; a new sum SHALL be captured every cycle.
- REQ-013: A zero result SHALL be all-zero bits; there is no negative zero in two's complement.
- REQ-014: Operands of mixed sign SHALL produce the exact signed result, e.g. -8 + 7 = -1 (5'b11111).

Reset
- REQ-015: Asserting reset SHALL force C to 0 immediately, without waiting for a clock edge.
- REQ-016: While reset is high, C SHALL remain 0 on every clk edge, regardless of A and B.
- REQ-017: After reset deasserts, the first rising clk edge SHALL load A+B into C.
- REQ-018: Reset asserted mid-operation SHALL discard the current sum, and C SHALL read 0 until reset is released.
- REQ-019: The module SHALL contain no other state.

Verification
- REQ-020: Reset high across one clock with A=-8, B=-8 -> C=0 at the next falling edge.
- REQ-021: Corner sweep, one pair per cycle, checked at each falling edge:
  - (-8,-8) -> -16
  - (0,0) -> 0
  - (-8,7) -> -1
  - (7,0) -> 7
  - (0,-8) -> -8
  - (7,7) -> 14
  - (-8,0) -> -8
  - (7,-8) -> -1
  - (0,7) -> 7
- REQ-022: Latency check: change A from 7 to -8 with B=7 just after a rising edge -> C stays 14 until the next rising edge, then becomes -1.
- REQ-023: Asynchronous reset check: with C=14, assert reset between clock edges -> C=0 before the next clock edge.
- REQ-024: Reset release check: deassert reset with A=-8, B=0 -> C=-8 after the first rising edge.
- REQ-025: Exhaustive check: all 256 (A,B) pairs, one pair per cycle -> C equals the signed 5-bit sum one cycle later, with zero mismatches reported.
